// File: rtl/dram_cmd_scheduler_if.sv
// Request/refresh/command bundle between the address-decode stage, the
// DDR4 command scheduler and the command bus.
interface dram_cmd_scheduler_if;
  logic        req_valid;
  logic        req_ready;
  logic [16:0] req_addr;
  logic [1:0]  req_bg;
  logic [1:0]  req_ba;
  logic        req_we;
  logic        ref_req;
  logic        ref_ack;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [16:0] cmd_addr;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_ba;

  modport master (
    output req_valid, req_addr, req_bg, req_ba, req_we, ref_req,
    input  req_ready, ref_ack, cmd_valid, cmd, cmd_addr, cmd_bg, cmd_ba
  );

  modport slave (
    input  req_valid, req_addr, req_bg, req_ba, req_we, ref_req,
    output req_ready, ref_ack, cmd_valid, cmd, cmd_addr, cmd_bg, cmd_ba
  );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// Per-request DDR4 command sequencer: tracks open rows of 16 banks and issues
// PRE/ACT/RD/WR with tRP/tRCD spacing, plus PREA/REF refresh with tRFC.
module dram_cmd_scheduler #(
  parameter int ROW_BITS = 8,
  parameter int COL_BITS = 4,
  parameter int T_RP     = 3,
  parameter int T_RCD    = 3,
  parameter int T_RFC    = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  dram_cmd_scheduler_if.slave  bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PRE      = 4'd1;
  localparam logic [3:0] S_WAIT_RP  = 4'd2;
  localparam logic [3:0] S_ACT      = 4'd3;
  localparam logic [3:0] S_WAIT_RCD = 4'd4;
  localparam logic [3:0] S_RW       = 4'd5;
  localparam logic [3:0] S_PREA     = 4'd6;
  localparam logic [3:0] S_WAIT_RPA = 4'd7;
  localparam logic [3:0] S_REF      = 4'd8;
  localparam logic [3:0] S_WAIT_RFC = 4'd9;

  localparam logic [2:0] C_NOP  = 3'b000;
  localparam logic [2:0] C_ACT  = 3'b001;
  localparam logic [2:0] C_RD   = 3'b010;
  localparam logic [2:0] C_WR   = 3'b011;
  localparam logic [2:0] C_PRE  = 3'b100;
  localparam logic [2:0] C_PREA = 3'b101;
  localparam logic [2:0] C_REF  = 3'b110;

  localparam int T_MAX0 = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int T_MAX  = (T_MAX0 > T_RFC) ? T_MAX0 : T_RFC;
  localparam int CNT_W  = $clog2(T_MAX + 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RCD_LAST = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RFC_LAST = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         open_q;
  logic [ROW_BITS-1:0] row_tbl_q [16];
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic [1:0]          bg_q, ba_q;
  logic                we_q;
  logic                ref_ack_q, ref_ack_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [16:0]         cmd_addr_q, cmd_addr_d;
  logic [1:0]          cmd_bg_q, cmd_bg_d, cmd_ba_q, cmd_ba_d;

  logic [3:0]          idx_in, idx_q;
  logic [ROW_BITS-1:0] req_row;
  logic                accept, ref_go;

  assign idx_in  = {bus.req_bg, bus.req_ba};
  assign idx_q   = {bg_q, ba_q};
  assign req_row = bus.req_addr[ROW_BITS+COL_BITS-1:COL_BITS];

  generate
    if (ROW_BITS + COL_BITS < 17) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^bus.req_addr[16:ROW_BITS+COL_BITS];
    end
  endgenerate

  assign bus.req_ready = rst_n && (state_q == S_IDLE) && !bus.ref_req;
  assign accept        = bus.req_valid && bus.req_ready;
  // ref_req may still be high while the ack is on the bus; don't restart refresh.
  assign ref_go        = bus.ref_req && !ref_ack_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ref_go)
          state_d = (|open_q) ? S_PREA : S_REF;
        else if (accept) begin
          if (!open_q[idx_in])                 state_d = S_ACT;
          else if (row_tbl_q[idx_in] == req_row) state_d = S_RW;
          else                                 state_d = S_PRE;
        end
      end
      S_PRE: begin
        cnt_d   = CNT_ONE;
        state_d = (T_RP == 1) ? S_ACT : S_WAIT_RP;
      end
      S_WAIT_RP:  if (cnt_q == RP_LAST) state_d = S_ACT; else cnt_d = cnt_q + 1'b1;
      S_ACT: begin
        cnt_d   = CNT_ONE;
        state_d = (T_RCD == 1) ? S_RW : S_WAIT_RCD;
      end
      S_WAIT_RCD: if (cnt_q == RCD_LAST) state_d = S_RW; else cnt_d = cnt_q + 1'b1;
      S_RW:       state_d = S_IDLE;
      S_PREA: begin
        cnt_d   = CNT_ONE;
        state_d = (T_RP == 1) ? S_REF : S_WAIT_RPA;
      end
      S_WAIT_RPA: if (cnt_q == RP_LAST) state_d = S_REF; else cnt_d = cnt_q + 1'b1;
      S_REF: begin
        cnt_d   = CNT_ONE;
        state_d = (T_RFC == 1) ? S_IDLE : S_WAIT_RFC;
      end
      S_WAIT_RFC: if (cnt_q == RFC_LAST) state_d = S_IDLE; else cnt_d = cnt_q + 1'b1;
      default:    state_d = S_IDLE;
    endcase
  end

  // The command bus shows, one cycle later, the command of the state just left.
  always_comb begin
    cmd_valid_d = 1'b0;
    cmd_d       = C_NOP;
    cmd_addr_d  = '0;
    cmd_bg_d    = '0;
    cmd_ba_d    = '0;
    case (state_q)
      S_ACT: begin
        cmd_valid_d = 1'b1;
        cmd_d       = C_ACT;
        cmd_addr_d  = 17'(row_q);
        cmd_bg_d    = bg_q;
        cmd_ba_d    = ba_q;
      end
      S_RW: begin
        cmd_valid_d = 1'b1;
        cmd_d       = we_q ? C_WR : C_RD;
        cmd_addr_d  = 17'(col_q);
        cmd_bg_d    = bg_q;
        cmd_ba_d    = ba_q;
      end
      S_PRE: begin
        cmd_valid_d = 1'b1;
        cmd_d       = C_PRE;
        cmd_bg_d    = bg_q;
        cmd_ba_d    = ba_q;
      end
      S_PREA: begin
        cmd_valid_d = 1'b1;
        cmd_d       = C_PREA;
      end
      S_REF: begin
        cmd_valid_d = 1'b1;
        cmd_d       = C_REF;
      end
      default: ;
    endcase
    ref_ack_d = ((state_q == S_WAIT_RFC) && (cnt_q == RFC_LAST)) ||
                ((state_q == S_REF) && (T_RFC == 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      open_q      <= '0;
      ref_ack_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= C_NOP;
      cmd_addr_q  <= '0;
      cmd_bg_q    <= '0;
      cmd_ba_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_ack_q   <= ref_ack_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_bg_q    <= cmd_bg_d;
      cmd_ba_q    <= cmd_ba_d;
      if (state_q == S_PREA)     open_q         <= '0;
      else if (state_q == S_PRE) open_q[idx_q]  <= 1'b0;
      else if (state_q == S_ACT) open_q[idx_q]  <= 1'b1;
    end
  end

  // Request fields and row contents are qualified by the FSM and open bits.
  always_ff @(posedge clk) begin
    if (accept) begin
      row_q <= req_row;
      col_q <= bus.req_addr[COL_BITS-1:0];
      bg_q  <= bus.req_bg;
      ba_q  <= bus.req_ba;
      we_q  <= bus.req_we;
    end
    if (state_q == S_ACT) row_tbl_q[idx_q] <= row_q;
  end

  assign bus.ref_ack   = ref_ack_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.cmd_bg    = cmd_bg_q;
  assign bus.cmd_ba    = cmd_ba_q;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed bench for dram_cmd_scheduler: row hit/closed/miss sequencing,
// refresh with open and closed banks, and mid-sequence reset.
module tb_dram_cmd_scheduler;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] ACT  = 3'b001;
  localparam logic [2:0] RD   = 3'b010;
  localparam logic [2:0] WR   = 3'b011;
  localparam logic [2:0] PRE  = 3'b100;
  localparam logic [2:0] PREA = 3'b101;
  localparam logic [2:0] REF  = 3'b110;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  dram_cmd_scheduler_if bus ();

  dram_cmd_scheduler #(
    .ROW_BITS(8), .COL_BITS(4), .T_RP(3), .T_RCD(3), .T_RFC(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cmd(input string tag, input logic v, input logic [2:0] c,
                         input logic [16:0] a, input logic [1:0] g, input logic [1:0] b);
    chk({tag, ".valid"}, 32'(bus.cmd_valid), 32'(v));
    chk({tag, ".cmd"},   32'(bus.cmd),       32'(c));
    chk({tag, ".addr"},  32'(bus.cmd_addr),  32'(a));
    chk({tag, ".bg"},    32'(bus.cmd_bg),    32'(g));
    chk({tag, ".ba"},    32'(bus.cmd_ba),    32'(b));
  endtask

  // Present a request while IDLE and complete the handshake (edge 0).
  task automatic send(input string tag, input logic [16:0] a, input logic [1:0] g,
                      input logic [1:0] b, input logic we);
    bus.req_addr  = a;
    bus.req_bg    = g;
    bus.req_ba    = b;
    bus.req_we    = we;
    bus.req_valid = 1'b1;
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_bg    = '0;
    bus.req_ba    = '0;
    bus.req_we    = 1'b0;
    bus.ref_req   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(bus.req_ready), 32'd0);
    chk("rst.ack",   32'(bus.ref_ack),   32'd0);
    chk_cmd("rst", 1'b0, NOP, 17'h0, 2'd0, 2'd0);
    rst_n = 1'b1;
    tick();

    // Closed bank: ACT cycle 1, RD cycle 4
    send("t1", 17'h0125, 2'd1, 2'd2, 1'b0);
    tick(); chk_cmd("t1.act", 1'b1, ACT, 17'h00012, 2'd1, 2'd2);
    tick(); chk("t1.c2", 32'(bus.cmd_valid), 32'd0);
    tick(); chk("t1.c3", 32'(bus.cmd_valid), 32'd0);
    tick(); chk_cmd("t1.rd", 1'b1, RD, 17'h00005, 2'd1, 2'd2);

    // Row hit: WR cycle 1, nothing else
    send("t2", 17'h012A, 2'd1, 2'd2, 1'b1);
    tick(); chk_cmd("t2.wr", 1'b1, WR, 17'h0000A, 2'd1, 2'd2);
    tick(); chk("t2.c2", 32'(bus.cmd_valid), 32'd0);

    // Row miss: PRE 1, ACT 4, RD 7
    send("t3", 17'h0345, 2'd1, 2'd2, 1'b0);
    tick(); chk_cmd("t3.pre", 1'b1, PRE, 17'h0, 2'd1, 2'd2);
    tick(); chk("t3.c2", 32'(bus.cmd_valid), 32'd0);
    tick();
    tick(); chk_cmd("t3.act", 1'b1, ACT, 17'h00034, 2'd1, 2'd2);
    tick(); chk("t3.c5", 32'(bus.cmd_valid), 32'd0);
    tick();
    tick(); chk_cmd("t3.rd", 1'b1, RD, 17'h00005, 2'd1, 2'd2);

    // Row 0x34 now open: hit
    send("t3h", 17'h0343, 2'd1, 2'd2, 1'b1);
    tick(); chk_cmd("t3h.wr", 1'b1, WR, 17'h00003, 2'd1, 2'd2);

    // Refresh with a bank open, request held alongside
    bus.ref_req   = 1'b1;
    bus.req_addr  = 17'h0125;
    bus.req_bg    = 2'd1;
    bus.req_ba    = 2'd2;
    bus.req_we    = 1'b0;
    bus.req_valid = 1'b1;
    #1;
    chk("t4.ready0", 32'(bus.req_ready), 32'd0);
    tick();
    for (int c = 1; c <= 11; c++) begin
      tick();
      chk($sformatf("t4.ready.c%0d", c), 32'(bus.req_ready), 32'd0);
      chk($sformatf("t4.ack.c%0d", c), 32'(bus.ref_ack), 32'(c == 11));
      chk_cmd($sformatf("t4.c%0d", c), (c == 1) || (c == 4),
              (c == 1) ? PREA : ((c == 4) ? REF : NOP), 17'h0, 2'd0, 2'd0);
    end
    bus.ref_req = 1'b0;
    #1;
    chk("t4.ready1", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk_cmd("t4.act", 1'b1, ACT, 17'h00012, 2'd1, 2'd2);
    chk("t4.ack.after", 32'(bus.ref_ack), 32'd0);

    // Reset during WAIT_RCD
    rst_n = 1'b0;
    #1;
    chk_cmd("t5.rst", 1'b0, NOP, 17'h0, 2'd0, 2'd0);
    chk("t5.ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Refresh with all banks closed: REF cycle 1, ack cycle 8
    bus.ref_req = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("t6.ack.c%0d", c), 32'(bus.ref_ack), 32'(c == 8));
      chk_cmd($sformatf("t6.c%0d", c), c == 1, (c == 1) ? REF : NOP, 17'h0, 2'd0, 2'd0);
    end
    bus.ref_req = 1'b0;
    tick();

    // Table was cleared by reset: ACT, not RD
    send("t7", 17'h0125, 2'd1, 2'd2, 1'b0);
    tick(); chk_cmd("t7.act", 1'b1, ACT, 17'h00012, 2'd1, 2'd2);
    tick(); chk("t7.c2", 32'(bus.cmd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
